// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode-control and ID/EX pipeline register of the 5-stage RISC-V core.
// It decodes the main control bundle from the ID opcode and detects load-use
// hazards against the instruction currently in EX. It drives PC/IF-ID write
// enables and the IF/ID flush back to the front end. It inserts a bubble on a
// stall or a taken branch. It also counts load-use stall cycles with a
// saturating counter.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   *_ID                  PC, immediate, operands and fields of the ID instruction
//   PCSrc                 taken branch resolved in EX (flush request)
//   PC_write, IF_ID_write front-end enables (combinational)
//   IF_ID_flush           clear IF/ID to NOP (combinational, equals PCSrc)
//   *_EX                  registered operands, fields and control for EX
//   STALL_COUNT           saturating count of load-use stall cycles
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC_ID,
  input  logic [31:0]      IMM_ID,
  input  logic [31:0]      REG_DATA1_ID,
  input  logic [31:0]      REG_DATA2_ID,
  input  logic [6:0]       OPCODE_ID,
  input  logic [2:0]       FUNCT3_ID,
  input  logic [6:0]       FUNCT7_ID,
  input  logic [4:0]       RD_ID,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             PCSrc,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic [31:0]      PC_EX,
  output logic [31:0]      IMM_EX,
  output logic [31:0]      REG_DATA1_EX,
  output logic [31:0]      REG_DATA2_EX,
  output logic [2:0]       FUNCT3_EX,
  output logic [6:0]       FUNCT7_EX,
  output logic [4:0]       RD_EX,
  output logic [4:0]       RS1_EX,
  output logic [4:0]       RS2_EX,
  output logic             RegWrite_EX,
  output logic             MemtoReg_EX,
  output logic             MemRead_EX,
  output logic             MemWrite_EX,
  output logic             Branch_EX,
  output logic             ALUSrc_EX,
  output logic [1:0]       ALUOp_EX,
  output logic [CNT_W-1:0] STALL_COUNT
);

  // Control bundle order: RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[1:0]
  logic [7:0]       ctl_dec_s;
  logic [7:0]       ctl_d;
  logic [7:0]       ctl_q;
  logic             hazard_s;
  logic             bubble_s;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Main control decode of the ID opcode; unknown opcodes decode as NOP
  always_comb begin
    ctl_dec_s = 8'b0000_0000;
    case (OPCODE_ID)
      7'b0110011: ctl_dec_s = 8'b1000_0010; // R-type
      7'b0010011: ctl_dec_s = 8'b1000_0111; // I-ALU
      7'b0000011: ctl_dec_s = 8'b1110_0100; // load
      7'b0100011: ctl_dec_s = 8'b0001_0100; // store
      7'b1100011: ctl_dec_s = 8'b0000_1001; // branch
      default:    ctl_dec_s = 8'b0000_0000;
    endcase
  end

  // Load-use hazard detection, bubble selection and front-end enables.
  // RS2 is compared for every format; a false stall is harmless.
  always_comb begin
    hazard_s    = ctl_q[5] && (RD_EX != 5'd0) &&
                  ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));
    bubble_s    = PCSrc || hazard_s;
    // Flush wins over the hazard: the held instruction is discarded anyway
    PC_write    = PCSrc || !hazard_s;
    IF_ID_write = PCSrc || !hazard_s;
    IF_ID_flush = PCSrc;
    if (bubble_s) begin
      ctl_d = 8'b0000_0000;
    end else begin
      ctl_d = ctl_dec_s;
    end
  end

  // Saturating stall counter next state; only real stalls count, not flushes
  always_comb begin
    if (hazard_s && !PCSrc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // ID/EX pipeline registers and stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC_EX        <= 32'd0;
      IMM_EX       <= 32'd0;
      REG_DATA1_EX <= 32'd0;
      REG_DATA2_EX <= 32'd0;
      FUNCT3_EX    <= 3'd0;
      FUNCT7_EX    <= 7'd0;
      RD_EX        <= 5'd0;
      RS1_EX       <= 5'd0;
      RS2_EX       <= 5'd0;
      ctl_q        <= 8'd0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      // Data and fields load even on a bubble; they are don't-care downstream
      PC_EX        <= PC_ID;
      IMM_EX       <= IMM_ID;
      REG_DATA1_EX <= REG_DATA1_ID;
      REG_DATA2_EX <= REG_DATA2_ID;
      FUNCT3_EX    <= FUNCT3_ID;
      FUNCT7_EX    <= FUNCT7_ID;
      RD_EX        <= RD_ID;
      RS1_EX       <= RS1_ID;
      RS2_EX       <= RS2_ID;
      ctl_q        <= ctl_d;
      cnt_q        <= cnt_d;
    end
  end

  assign RegWrite_EX = ctl_q[7];
  assign MemtoReg_EX = ctl_q[6];
  assign MemRead_EX  = ctl_q[5];
  assign MemWrite_EX = ctl_q[4];
  assign Branch_EX   = ctl_q[3];
  assign ALUSrc_EX   = ctl_q[2];
  assign ALUOp_EX    = ctl_q[1:0];
  assign STALL_COUNT = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage (CNT_W=4 so saturation is reachable).
// Expected EX contents are pushed to a scoreboard queue when an ID instruction
// is driven and popped/compared after the capturing edge.
module tb_id_ex_stage;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [31:0]   PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
  logic [6:0]    OPCODE_ID, FUNCT7_ID;
  logic [2:0]    FUNCT3_ID;
  logic [4:0]    RD_ID, RS1_ID, RS2_ID;
  logic          PCSrc;
  logic          PC_write, IF_ID_write, IF_ID_flush;
  logic [31:0]   PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
  logic [2:0]    FUNCT3_EX;
  logic [6:0]    FUNCT7_EX;
  logic [4:0]    RD_EX, RS1_EX, RS2_EX;
  logic          RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ALUSrc_EX;
  logic [1:0]    ALUOp_EX;
  logic [CW-1:0] STALL_COUNT;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .PC_ID(PC_ID), .IMM_ID(IMM_ID), .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
    .OPCODE_ID(OPCODE_ID), .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID),
    .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .PCSrc(PCSrc),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .PC_EX(PC_EX), .IMM_EX(IMM_EX), .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
    .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX), .ALUSrc_EX(ALUSrc_EX),
    .ALUOp_EX(ALUOp_EX), .STALL_COUNT(STALL_COUNT)
  );

  typedef struct packed {
    logic [7:0]    ctl;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic [31:0]   d1;
    logic [31:0]   d2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp;
  int            n_err;
  // Bench-side model state: what the model believes is in EX
  logic          m_memread;
  logic [4:0]    m_rd;
  logic [CW-1:0] m_cnt;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference control table {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp}
  function automatic logic [7:0] ref_ctl(input logic [6:0] op);
    logic rw, m2r, mr, mw, br, src;
    logic [1:0] aop;
    rw = 1'b0; m2r = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; src = 1'b0; aop = 2'b00;
    if (op == OP_R)  begin rw = 1'b1; aop = 2'b10; end
    if (op == OP_I)  begin rw = 1'b1; src = 1'b1; aop = 2'b11; end
    if (op == OP_LD) begin rw = 1'b1; mr = 1'b1; m2r = 1'b1; src = 1'b1; end
    if (op == OP_ST) begin mw = 1'b1; src = 1'b1; end
    if (op == OP_BR) begin br = 1'b1; aop = 2'b01; end
    return {rw, m2r, mr, mw, br, src, aop};
  endfunction

  function automatic logic [7:0] got_ctl();
    return {RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ALUSrc_EX, ALUOp_EX};
  endfunction

  // One pipeline cycle: drive ID, check the front-end enables, then the EX capture
  task automatic step(input string tag, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] d1, input logic [31:0] d2, input logic br_taken);
    exp_t e;
    exp_t g;
    logic hz;
    @(negedge clk);
    OPCODE_ID = op; RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
    REG_DATA1_ID = d1; REG_DATA2_ID = d2; PCSrc = br_taken;
    PC_ID = $urandom; IMM_ID = $urandom;
    FUNCT3_ID = 3'($urandom_range(0, 7)); FUNCT7_ID = 7'($urandom_range(0, 127));
    #1;
    hz = m_memread && (m_rd != 5'd0) && ((m_rd == rs1) || (m_rd == rs2));
    check({tag, ".PC_write"},    {63'd0, PC_write},    {63'd0, (br_taken || !hz)});
    check({tag, ".IF_ID_write"}, {63'd0, IF_ID_write}, {63'd0, (br_taken || !hz)});
    check({tag, ".IF_ID_flush"}, {63'd0, IF_ID_flush}, {63'd0, br_taken});
    if (hz && !br_taken && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
    e.ctl = (hz || br_taken) ? 8'd0 : ref_ctl(op);
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = FUNCT3_ID; e.f7 = FUNCT7_ID;
    e.pc = PC_ID; e.imm = IMM_ID; e.d1 = d1; e.d2 = d2; e.cnt = m_cnt;
    sb_q.push_back(e);
    m_memread = e.ctl[5];
    m_rd = rd;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    g = '{got_ctl(), RD_EX, RS1_EX, RS2_EX, FUNCT3_EX, FUNCT7_EX,
          PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX, STALL_COUNT};
    check({tag, ".ctl"},    {56'd0, g.ctl}, {56'd0, e.ctl});
    check({tag, ".fields"}, {37'd0, g.rd, g.rs1, g.rs2, g.f3, g.f7}, {37'd0, e.rd, e.rs1, e.rs2, e.f3, e.f7});
    check({tag, ".pc_imm"}, {g.pc, g.imm}, {e.pc, e.imm});
    check({tag, ".data"},   {g.d1, g.d2},  {e.d1, e.d2});
    check({tag, ".cnt"},    {60'd0, g.cnt}, {60'd0, e.cnt});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".ctl"},    {56'd0, got_ctl()}, 64'd0);
    check({tag, ".data"},   {REG_DATA1_EX, REG_DATA2_EX}, 64'd0);
    check({tag, ".pc_imm"}, {PC_EX, IMM_EX}, 64'd0);
    check({tag, ".fields"}, {37'd0, RD_EX, RS1_EX, RS2_EX, FUNCT3_EX, FUNCT7_EX}, 64'd0);
    check({tag, ".cnt"},    {60'd0, STALL_COUNT}, 64'd0);
    check({tag, ".PC_write"},    {63'd0, PC_write},    64'd1);
    check({tag, ".IF_ID_write"}, {63'd0, IF_ID_write}, 64'd1);
    check({tag, ".IF_ID_flush"}, {63'd0, IF_ID_flush}, 64'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_memread = 1'b0; m_rd = 5'd0; m_cnt = 4'd0;
    reset = 1'b0; PCSrc = 1'b0;
    PC_ID = 32'd0; IMM_ID = 32'd0; REG_DATA1_ID = 32'd0; REG_DATA2_ID = 32'd0;
    OPCODE_ID = 7'd0; FUNCT3_ID = 3'd0; FUNCT7_ID = 7'd0;
    RD_ID = 5'd0; RS1_ID = 5'd0; RS2_ID = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    @(negedge clk);
    reset = 1'b1;

    // Decode and capture of each opcode class
    step("add",   OP_R,  5'd3,  5'd1, 5'd2, 32'd5, 32'd7, 1'b0);
    step("addi",  OP_I,  5'd4,  5'd3, 5'd0, 32'd9, 32'd0, 1'b0);
    step("sw",    OP_ST, 5'd0,  5'd2, 5'd4, 32'h100, 32'h55, 1'b0);
    step("beq",   OP_BR, 5'd0,  5'd3, 5'd4, 32'd1, 32'd1, 1'b0);
    step("nop",   7'b1111111, 5'd7, 5'd8, 5'd9, 32'hDEAD, 32'hBEEF, 1'b0);

    // Load-use: lw x5 then add x6,x5,x2 stalls once, then proceeds
    step("lw5",   OP_LD, 5'd5, 5'd1, 5'd0, 32'h40, 32'd0, 1'b0);
    step("stall", OP_R,  5'd6, 5'd5, 5'd2, 32'd11, 32'd12, 1'b0);
    step("held",  OP_R,  5'd6, 5'd5, 5'd2, 32'd11, 32'd12, 1'b0);
    check("cnt_after_stall", {60'd0, STALL_COUNT}, 64'd1);

    // Load-use through rs2 also stalls
    step("lw7",    OP_LD, 5'd7, 5'd1, 5'd0, 32'h44, 32'd0, 1'b0);
    step("stall2", OP_R,  5'd8, 5'd3, 5'd7, 32'd1, 32'd2, 1'b0);
    step("held2",  OP_R,  5'd8, 5'd3, 5'd7, 32'd1, 32'd2, 1'b0);

    // No false stall on x0
    step("lw0",   OP_LD, 5'd0, 5'd1, 5'd0, 32'h40, 32'd0, 1'b0);
    step("x0use", OP_R,  5'd6, 5'd0, 5'd2, 32'd3, 32'd4, 1'b0);

    // Flush has priority over a live hazard and is not counted
    step("lw5f",  OP_LD, 5'd5, 5'd1, 5'd0, 32'h48, 32'd0, 1'b0);
    step("flush", OP_R,  5'd6, 5'd5, 5'd2, 32'd3, 32'd4, 1'b1);
    step("post",  OP_I,  5'd9, 5'd5, 5'd5, 32'd6, 32'd0, 1'b0);

    // Saturation: 17 more stalls push the 4-bit counter to all-ones and hold it
    for (int i = 0; i < 17; i++) begin
      step("sat_lw",   OP_LD, 5'd10, 5'd1,  5'd0,  32'(i), 32'd0, 1'b0);
      step("sat_use",  OP_R,  5'd11, 5'd10, 5'd2,  32'(i), 32'd1, 1'b0);
      step("sat_held", OP_R,  5'd11, 5'd10, 5'd2,  32'(i), 32'd1, 1'b0);
    end
    check("cnt_saturated", {60'd0, STALL_COUNT}, 64'd15);

    // Reset mid-stall, asserted between edges
    step("lw12", OP_LD, 5'd12, 5'd1, 5'd0, 32'h80, 32'd0, 1'b0);
    @(negedge clk);
    OPCODE_ID = OP_R; RD_ID = 5'd13; RS1_ID = 5'd12; RS2_ID = 5'd2;
    #1;
    check("midstall.PC_write", {63'd0, PC_write}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("rst_mid");
    m_memread = 1'b0; m_rd = 5'd0; m_cnt = 4'd0;
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    reset = 1'b1;

    // First capture after release
    step("after_rst", OP_R, 5'd13, 5'd12, 5'd2, 32'd21, 32'd22, 1'b0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
